eth_pcs_tx_gearbox: RTL and testbench
=====================================

# eth_pcs_tx_gearbox

Transmit-side 66:64 gearbox for the 10GBASE-R PCS. It accepts one W_DATA-bit scrambled payload word per enabled cycle, plus a W_SYNC-bit sync header on the first word of each 66-bit block. It repacks the 66-bit stream into a continuous W_DATA-bit PMA word every clock. It sits between the TX scrambler and the PMA serializer and throttles the upstream encoder/scrambler through o_clk_en.

## Interface
- W_DATA, 32, PMA and payload word width; taken from eth_pcs_params; only 32 is supported.
- W_SYNC, 2, sync header width; taken from eth_pcs_params.
- i_clk  in  1  PCS transmit clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_hdr  in  W_SYNC  sync header for the block; sampled only on a header word.
- i_data  in  W_DATA  scrambled payload word; sampled when o_clk_en=1.
- o_clk_en  out  1  upstream advance/accept strobe; upstream presents a new word every cycle it is high.
- o_pma_data  out  W_DATA  serial-order PMA word; bit 0 is transmitted first.

## Operation
- Stream order per block: i_hdr[0], i_hdr[1], then payload bit 0 upward. Of each block's two words, the first (header word) carries i_hdr.
- Sequence counter seq runs 0..32 and wraps 32→0.
  - seq 0..31: accept cycles, o_clk_en=1.
  - seq 32: pause cycle, o_clk_en=0, no input sampled.
- Half flag h:
  - Cleared at reset.
  - Toggles on every accept cycle.
  - h=0 marks a header word.
  - A period holds 32 accepts, so h is always 0 at seq 0 and blocks never straddle a pause.
- Residual buffer holds unsent bits, R bits (0..32).
- Per-cycle packing:
  - Header accept: stream {i_data, i_hdr} (34 bits) is appended above the R residual bits.
  - Non-header accept: i_data (32 bits) is appended above the R residual bits.
  - Pause: nothing is appended.
  - In every case, the low 32 bits go to o_pma_data and the rest become the new residual.
- R after the accept at seq k is 2*ceil((k+1)/2). R=32 after seq 31. The pause drains R to 0.
- Throughput: 16 blocks = 1056 bits = 33 output words per 33-cycle period. No overflow or underflow is possible.
- Upstream must hold i_data/i_hdr stable while o_clk_en=0. Values presented during a pause are ignored.

## Timing
- Reset (i_reset=1 at a clock edge):
  - o_pma_data=0, o_clk_en=0.
  - seq=0, h=0, residual cleared.
  - Applies regardless of mid-block or mid-period state; partial blocks are discarded.
- First cycle after reset deassertion: o_clk_en=1 (seq 0). o_clk_en is a registered output, derived from the next-state seq.
- Latency: the word accepted at cycle t contributes its low bits to o_pma_data at cycle t+1 (registered output).
- Output is continuous. After reset, o_pma_data carries valid bits every cycle, including the cycle following a pause.
- Pause pattern after reset: 32 cycles with o_clk_en=1, then 1 cycle low, repeating.

## Configuration
- ETH_PCS_TX_GRBX_HDR_FIX_EN:
  - Defined: an invalid header (2'b00 or 2'b11) on a header word is replaced by 2'b10 before packing.
  - Undefined: headers pass unmodified.
  - The macro changes no ports or timing.

## Structure
- eth_pcs_params provides:
  - W_DATA and W_SYNC.
  - New constants: GRBX_PERIOD=33 and GRBX_SYNC_CTRL=2'b10.
  - Typedef grbx_seq_t, 6 bits.
- No sub-module is required. Sequence counter, half flag, residual register and packing shifter live in one module.

## Test plan
- Hold i_reset=1 for 5 cycles → o_pma_data=0 and o_clk_en=0 throughout. After release, o_clk_en shows 32 high, 1 low, repeating, checked over 3 periods.
- First header word i_hdr=2'b10, i_data=32'hFFFF_FFFF → o_pma_data=32'hFFFF_FFFE next cycle, residual=2'b11.
- 160 random blocks (10 periods) → deserialized o_pma_data matches the reference {hdr,data} 66-bit stream bit-exact against a scoreboard. No bit gaps across pause cycles.
- Reset asserted at seq 17 (mid-block) → next cycle o_pma_data=0 and o_clk_en=0. After release, a new block aligns at seq 0 with the correct first word.
- Header word i_hdr=2'b00, i_data=0:
  - With ETH_PCS_TX_GRBX_HDR_FIX_EN: o_pma_data low two bits = 2'b10.
  - Without it: o_pma_data low two bits = 2'b00.
- Change i_data during the pause cycle (seq 32) → output stream unaffected, checked by the scoreboard.

Source files
------------

// File: rtl/eth_pcs_params.sv
// Shared constants and types for the 10GBASE-R PCS transmit path.
// GRBX_* items belong to the 66:64 TX gearbox.
package eth_pcs_params;

  localparam int W_DATA = 32;
  localparam int W_SYNC = 2;

  // One gearbox period: 32 accept cycles followed by 1 pause cycle.
  localparam int GRBX_PERIOD = 33;

  // Control-block sync header, used as the replacement for invalid headers.
  localparam logic [W_SYNC-1:0] GRBX_SYNC_CTRL = 2'b10;

  typedef logic [5:0] grbx_seq_t;

  // Sequence value of the pause cycle.
  localparam grbx_seq_t GRBX_SEQ_PAUSE = grbx_seq_t'(GRBX_PERIOD - 1);

  // A sync header is legal only when its two bits differ (2'b01 or 2'b10).
  function automatic logic grbx_hdr_valid(input logic [W_SYNC-1:0] hdr);
    return hdr[0] ^ hdr[1];
  endfunction

endpackage

// File: rtl/eth_pcs_tx_gearbox.sv
// 10GBASE-R transmit 66:64 gearbox.
// Takes a 32-bit scrambled payload word per accept cycle, plus a 2-bit sync
// header on the first word of each 66-bit block. It repacks the stream into a
// continuous 32-bit PMA word every clock. Upstream is throttled by o_clk_en:
// 32 accept cycles, then 1 pause cycle during which the residual drains.
//
// Upstream handshake: o_clk_en high during a cycle means the i_hdr/i_data
// present in that cycle are consumed at the closing clock edge. o_clk_en low
// means nothing is consumed and the inputs are ignored.
//
// Optional build macro ETH_PCS_TX_GRBX_HDR_FIX_EN: when defined, an invalid
// header (2'b00 / 2'b11) on a header word is replaced by 2'b10 before packing.
module eth_pcs_tx_gearbox
  import eth_pcs_params::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [W_SYNC-1:0] i_hdr,
  input  logic [W_DATA-1:0] i_data,
  output logic              o_clk_en,
  output logic [W_DATA-1:0] o_pma_data
);

  localparam int W_STREAM = 2 * W_DATA;

  // Sequence position of the current cycle (valid for accept cycles and pause)
  grbx_seq_t         seq_q, seq_d;
  // Half flag: 0 means the next accepted word is a block's header word
  logic              h_q, h_d;
  // Unsent bits, LSB is the next bit on the wire
  logic [W_DATA-1:0] res_q, res_d;
  logic [5:0]        res_len_q, res_len_d;
  // Registered accept strobe for the current cycle
  logic              clk_en_q, clk_en_d;
  logic [W_DATA-1:0] pma_q, pma_d;

  logic [W_SYNC-1:0]   hdr_eff;
  logic [W_STREAM-1:0] in_bits;
  logic [6:0]          in_len;
  logic [6:0]          total_len;
  logic [W_STREAM-1:0] stream;

  // Header cleanup applied before the header enters the stream
  always_comb begin
    hdr_eff = i_hdr;
`ifdef ETH_PCS_TX_GRBX_HDR_FIX_EN
    if (!grbx_hdr_valid(i_hdr)) begin
      hdr_eff = GRBX_SYNC_CTRL;
    end
`else
    hdr_eff = i_hdr;
`endif
  end

  // Packing: append the accepted bits above the residual, emit the low word
  always_comb begin
    in_bits = '0;
    in_len  = '0;
    if (clk_en_q) begin
      if (!h_q) begin
        in_bits = {{(W_STREAM - W_DATA - W_SYNC){1'b0}}, i_data, hdr_eff};
        in_len  = 7'(W_DATA + W_SYNC);
      end else begin
        in_bits = {{(W_STREAM - W_DATA){1'b0}}, i_data};
        in_len  = 7'(W_DATA);
      end
    end
    // Header words only arrive with R <= 30 and payload words with R <= 32,
    // so the shifted stream never exceeds 64 bits.
    stream    = (in_bits << res_len_q) | {{(W_STREAM - W_DATA){1'b0}}, res_q};
    total_len = 7'(res_len_q) + in_len;
    pma_d     = stream[W_DATA-1:0];
    res_d     = stream[W_STREAM-1:W_DATA];
    // Only the idle cycle right after reset has fewer than 32 bits on hand.
    res_len_d = (total_len >= 7'(W_DATA)) ? 6'(total_len - 7'(W_DATA)) : '0;
  end

  // Sequencing: advance on accepts, restart at 0 after a pause or reset idle
  always_comb begin
    seq_d    = clk_en_q ? (seq_q + grbx_seq_t'(1)) : '0;
    h_d      = clk_en_q ? ~h_q : h_q;
    clk_en_d = (seq_d != GRBX_SEQ_PAUSE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      seq_q     <= '0;
      h_q       <= 1'b0;
      res_q     <= '0;
      res_len_q <= '0;
      clk_en_q  <= 1'b0;
      pma_q     <= '0;
    end else begin
      seq_q     <= seq_d;
      h_q       <= h_d;
      res_q     <= res_d;
      res_len_q <= res_len_d;
      clk_en_q  <= clk_en_d;
      pma_q     <= pma_d;
    end
  end

  assign o_clk_en   = clk_en_q;
  assign o_pma_data = pma_q;

endmodule

// File: tb/tb_eth_pcs_tx_gearbox.sv
// Testbench for eth_pcs_tx_gearbox.
// Honors ETH_PCS_TX_GRBX_HDR_FIX_EN when computing expected headers.
module tb_eth_pcs_tx_gearbox;

  logic        clk;
  logic        i_reset;
  logic [1:0]  i_hdr;
  logic [31:0] i_data;
  logic        o_clk_en;
  logic [31:0] o_pma_data;

  int checks;
  int passes;

  // Expected serial bit stream, front is the next bit on the wire
  logic exp_q[$];
  int   acc_cnt;

  eth_pcs_tx_gearbox dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_hdr      (i_hdr),
    .i_data     (i_data),
    .o_clk_en   (o_clk_en),
    .o_pma_data (o_pma_data)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %08h required %08h", name, got, exp);
    end else begin
      passes++;
    end
  endtask

  // Header as it should appear on the wire
  function automatic logic [1:0] wire_hdr(input logic [1:0] h);
`ifdef ETH_PCS_TX_GRBX_HDR_FIX_EN
    if (h == 2'b00 || h == 2'b11) return 2'b10;
    return h;
`else
    return h;
`endif
  endfunction

  // Append an accepted word to the expected stream; even accepts carry a header
  task automatic push_word(input logic [1:0] h, input logic [31:0] d);
    logic [1:0] wh;
    if ((acc_cnt % 2) == 0) begin
      wh = wire_hdr(h);
      exp_q.push_back(wh[0]);
      exp_q.push_back(wh[1]);
    end
    for (int b = 0; b < 32; b++) exp_q.push_back(d[b]);
    acc_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; holds reset for n edges, checking outputs stay cleared
  task automatic do_reset(input int n);
    i_reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_pma", o_pma_data, 32'h0);
      chk("reset_clk_en", {31'b0, o_clk_en}, 32'h0);
    end
    i_reset = 1'b0;
    // Advance to the first post-reset cycle (seq 0)
    @(negedge clk);
  endtask

  // Starts at the negedge of seq-0 cycle; drives random words for ncyc cycles
  task automatic run_stream(input int ncyc);
    logic [31:0] exp_w;
    logic [31:0] d;
    logic [1:0]  h;
    exp_q.delete();
    acc_cnt = 0;
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0) @(negedge clk);
      chk("clk_en_pattern", {31'b0, o_clk_en}, {31'b0, ((n % 33) != 32)});
      if (n == 0) begin
        chk("first_cycle_pma", o_pma_data, 32'h0);
      end else begin
        checks++;
        if (exp_q.size() < 32) begin
          $display("FAIL stream_underflow: got %0d queued bits required 32", exp_q.size());
        end else begin
          checks--;
          exp_w = '0;
          for (int b = 0; b < 32; b++) exp_w[b] = exp_q.pop_front();
          chk("stream_word", o_pma_data, exp_w);
        end
      end
      // Random values also during pause cycles; those must not reach the wire
      d = $urandom;
      h = 2'($urandom_range(0, 3));
      i_data = d;
      i_hdr  = h;
      if ((n % 33) != 32) push_word(h, d);
    end
  endtask

  // ---------------- table-driven first-block vectors ----------------
  typedef struct {
    logic [1:0]  hdr;
    logic [31:0] d0;
    logic [31:0] exp0;
    logic [31:0] d1;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs[6];

`ifdef ETH_PCS_TX_GRBX_HDR_FIX_EN
  localparam logic [31:0] HDR00_EXP = 32'h0000_0002;
  localparam logic [31:0] HDR11_EXP = 32'h0000_0002;
`else
  localparam logic [31:0] HDR00_EXP = 32'h0000_0000;
  localparam logic [31:0] HDR11_EXP = 32'h0000_0003;
`endif

  initial begin
    checks  = 0;
    passes  = 0;
    acc_cnt = 0;
    i_reset = 1'b1;
    i_hdr   = 2'b00;
    i_data  = '0;

    vecs[0] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0003};
    vecs[1] = '{2'b01, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[2] = '{2'b10, 32'h1234_5678, 32'h48D1_59E2, 32'hAAAA_AAAA, 32'hAAAA_AAA8};
    vecs[3] = '{2'b01, 32'h8000_0001, 32'h0000_0005, 32'h0000_0000, 32'h0000_0002};
    vecs[4] = '{2'b00, 32'h0000_0000, HDR00_EXP,     32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{2'b11, 32'h0000_0000, HDR11_EXP,     32'h0000_0000, 32'h0000_0000};

    @(negedge clk);

    // Long reset, then 10 periods of random blocks with continuous checking
    do_reset(5);
    run_stream(10 * 33 + 3);

    // First header word alignment and residual carry for each vector
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      do_reset(2);
      chk("vec_clk_en", {31'b0, o_clk_en}, 32'h1);
      i_hdr  = vecs[i].hdr;
      i_data = vecs[i].d0;
      @(negedge clk);
      chk("vec_word0", o_pma_data, vecs[i].exp0);
      i_hdr  = ~vecs[i].hdr;
      i_data = vecs[i].d1;
      @(negedge clk);
      chk("vec_word1", o_pma_data, vecs[i].exp1);
    end

    // Reset at seq 17, mid-block, then a fresh aligned stream
    @(negedge clk);
    do_reset(1);
    run_stream(17);
    @(negedge clk);
    i_reset = 1'b1;
    i_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("midreset_pma", o_pma_data, 32'h0);
    chk("midreset_clk_en", {31'b0, o_clk_en}, 32'h0);
    i_reset = 1'b0;
    @(negedge clk);
    run_stream(70);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
